aes128_encrypt: RTL and testbench

- Iterative AES-128 encryption core (FIPS-197), one round per clock.
- Takes a 128-bit plaintext block and a 128-bit cipher key and produces the 128-bit ciphertext.
- Used as the encryption datapath leaf in the AES subsystem.
- Round keys are expanded on the fly alongside the rounds, so no key RAM is needed.

---
 rtl/aes_pkg.sv | 50 +++++
 rtl/aes_sbox.sv | 25 ++
 rtl/aes128_encrypt.sv | 104 ++++++++++
 tb/tb_aes128_encrypt.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants and GF(2^8) helpers for the iterative encryption core.
package aes_pkg;

  typedef logic [127:0] block_t;

  localparam logic [7:0] Rcon [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  // Column word holds row 0 in its most significant byte.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] s0, s1, s2, s3;
    s0 = col[31:24];
    s1 = col[23:16];
    s2 = col[15:8];
    s3 = col[7:0];
    return {xtime(s0) ^ gmul3(s1) ^ s2 ^ s3,
            s0 ^ xtime(s1) ^ gmul3(s2) ^ s3,
            s0 ^ s1 ^ xtime(s2) ^ gmul3(s3),
            gmul3(s0) ^ s1 ^ s2 ^ xtime(s3)};
  endfunction

  function automatic int unsigned byte_idx(input int unsigned r, input int unsigned c);
    return 4 * c + r;
  endfunction

  function automatic int unsigned byte_msb(input int unsigned n);
    return 127 - 8 * n;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: GF(2^8) inverse via b^254, then the affine transform.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  logic [7:0] sq;
  logic [7:0] inv;

  // b^254 = b^2 * b^4 * ... * b^128; zero maps to zero naturally.
  always_comb begin
    sq  = in_i;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
  end

  assign out_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
                 {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes128_encrypt.sv
// Iterative AES-128 encryption, one round per clock, round keys expanded on the fly.
module aes128_encrypt
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] din,
  input  logic [127:0] key,
  output logic         busy,
  output logic         done,
  output logic [127:0] dout
);

  block_t      state_q, key_q, dout_q;
  logic [3:0]  round_q;
  logic        done_q;

  logic [7:0]  sb_out [16];
  block_t      sr_blk, mix_blk, key_nxt, round_out;
  logic [31:0] rot_w, sub_w, w4, w5, w6, w7;
  logic [3:0]  ridx;
  logic [7:0]  rcon;
  logic        last_round;

  for (genvar i = 0; i < 16; i++) begin : g_state_sbox
    aes_sbox u_sbox (
      .in_i  (state_q[127-8*i -: 8]),
      .out_o (sb_out[i])
    );
  end

  assign rot_w = {key_q[23:0], key_q[31:24]};

  for (genvar j = 0; j < 4; j++) begin : g_key_sbox
    aes_sbox u_sbox (
      .in_i  (rot_w[31-8*j -: 8]),
      .out_o (sub_w[31-8*j -: 8])
    );
  end

  assign ridx       = round_q - 4'd1;
  assign rcon       = (round_q != 4'd0) ? Rcon[ridx] : 8'h00;
  assign last_round = (round_q == 4'd10);

  assign w4      = key_q[127:96] ^ sub_w ^ {rcon, 24'h000000};
  assign w5      = key_q[95:64] ^ w4;
  assign w6      = key_q[63:32] ^ w5;
  assign w7      = key_q[31:0] ^ w6;
  assign key_nxt = {w4, w5, w6, w7};

  // ShiftRows is pure wiring over the substituted bytes: s'[r][c] = s[r][(c+r)%4].
  always_comb begin
    sr_blk  = '0;
    mix_blk = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        sr_blk[byte_msb(byte_idx(r, c)) -: 8] = sb_out[byte_idx(r, (c + r) % 4)];
      end
    end
    for (int unsigned c = 0; c < 4; c++) begin
      mix_blk[127-32*c -: 32] = mix_column(sr_blk[127-32*c -: 32]);
    end
  end

  assign round_out = (last_round ? sr_blk : mix_blk) ^ key_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      round_q <= 4'd0;
      done_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (round_q == 4'd0) begin
        if (start) round_q <= 4'd1;
      end else if (last_round) begin
        round_q <= 4'd0;
        done_q  <= 1'b1;
        dout_q  <= round_out;
      end else begin
        round_q <= round_q + 4'd1;
      end
    end
  end

  // Datapath registers need no reset; they are reloaded on every accepted start.
  always_ff @(posedge clk) begin
    if (round_q == 4'd0) begin
      if (start) begin
        state_q <= din ^ key;
        key_q   <= key;
      end
    end else begin
      state_q <= round_out;
      key_q   <= key_nxt;
    end
  end

  assign busy = (round_q != 4'd0);
  assign done = done_q;
  assign dout = dout_q;

endmodule

// File: tb/tb_aes128_encrypt.sv
// Self-checking bench for aes128_encrypt against a byte-array AES-128 reference model.
module tb_aes128_encrypt;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] din;
  logic [127:0] key;
  logic         busy;
  logic         done;
  logic [127:0] dout;

  int n_checks;
  int n_fail;
  int sbox_tab [256];

  aes128_encrypt dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .din   (din),
    .key   (key),
    .busy  (busy),
    .done  (done),
    .dout  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer GF arithmetic and textbook AES on byte arrays.
  function automatic int gmul(input int a, input int b);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++) begin
      if ((b & 1) != 0) p = p ^ a;
      a = a << 1;
      if ((a & 'h100) != 0) a = a ^ 'h11b;
      b = b >> 1;
    end
    return p & 'hff;
  endfunction

  function automatic void build_sbox();
    int inv;
    logic [7:0] iv;
    logic [7:0] cc;
    logic [7:0] o;
    cc = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = 0;
      for (int b = 1; b < 256; b++) if (a != 0 && gmul(a, b) == 1) inv = b;
      iv = inv[7:0];
      for (int i = 0; i < 8; i++)
        o[i] = iv[i] ^ iv[(i+4)%8] ^ iv[(i+5)%8] ^ iv[(i+6)%8] ^ iv[(i+7)%8] ^ cc[i];
      sbox_tab[a] = int'(o);
    end
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'(sbox_tab[w[8*i +: 8]]);
    return r;
  endfunction

  function automatic logic [127:0] ref_aes(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [31:0]  t;
    int           rc;
    int           s [4][4];
    int           tmp [4][4];
    logic [127:0] res;
    rc = 1;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc[7:0], 24'h0};
        rc = gmul(rc, 2);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r][c] = int'(pt[127-8*(4*c+r) -: 8]);
    for (int rnd = 0; rnd <= 10; rnd++) begin
      if (rnd > 0) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) tmp[r][c] = sbox_tab[s[r][(c+r)%4]];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) begin
            if (rnd == 10) s[r][c] = tmp[r][c];
            else s[r][c] = gmul(tmp[r][c], 2) ^ gmul(tmp[(r+1)%4][c], 3) ^
                           tmp[(r+2)%4][c] ^ tmp[(r+3)%4][c];
          end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ int'(w[4*rnd+c][31-8*r -: 8]);
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) res[127-8*(4*c+r) -: 8] = 8'(s[r][c]);
    return res;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [127:0] d, input logic [127:0] k);
    din   = d;
    key   = k;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Latency counted in edges after the start edge; 0 means the bound expired.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_check(input string tag, input logic [127:0] d, input logic [127:0] k,
                           input logic [127:0] exp);
    int lat;
    start_op(d, k);
    wait_done(lat);
    check({tag, "_lat"}, 128'(lat), 128'd10);
    check({tag, "_dout"}, dout, exp);
  endtask

  initial begin
    logic [127:0] d, k, exp_a, exp_b;
    int lat, pulses, first;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    din      = '0;
    key      = '0;
    build_sbox();

    tick();
    tick();
    check("rst_dout", dout, '0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    rst_n = 1'b1;
    tick();

    exp_a = 128'h3925841d02dc09fbdc118597196a0b32;
    check("ref_model_appb", ref_aes(128'h3243f6a8885a308d313198a2e0370734,
                                    128'h2b7e151628aed2a6abf7158809cf4f3c), exp_a);
    run_check("appb", 128'h3243f6a8885a308d313198a2e0370734,
              128'h2b7e151628aed2a6abf7158809cf4f3c, exp_a);
    tick();
    run_check("appc1", 128'h00112233445566778899aabbccddeeff,
              128'h000102030405060708090a0b0c0d0e0f,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    tick();
    run_check("zero", '0, '0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
    tick();

    // Start pulse and input changes while busy must not disturb the running op.
    start_op(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    din    = {$urandom, $urandom, $urandom, $urandom};
    key    = {$urandom, $urandom, $urandom, $urandom};
    pulses = 0;
    first  = 0;
    for (int i = 1; i <= 14; i++) begin
      start = (i == 4);
      tick();
      if (i == 4) check("busy_mid", 128'(busy), 128'd1);
      if (done === 1'b1) begin
        pulses++;
        if (first == 0) begin
          first = i;
          check("busy_ign_dout", dout, exp_a);
        end
      end
    end
    start = 1'b0;
    check("busy_ign_lat", 128'(first), 128'd10);
    check("busy_ign_pulses", 128'(pulses), 128'd1);

    // Back-to-back: second start issued in the done cycle.
    d = {$urandom, $urandom, $urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    exp_b = ref_aes(d, k);
    start_op(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f);
    wait_done(lat);
    check("b2b_first_lat", 128'(lat), 128'd10);
    check("b2b_first_dout", dout, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    start_op(d, k);
    check("b2b_done_drop", 128'(done), 128'd0);
    check("b2b_busy", 128'(busy), 128'd1);
    wait_done(lat);
    check("b2b_second_lat", 128'(lat), 128'd10);
    check("b2b_second_dout", dout, exp_b);
    tick();

    // Reset mid-operation aborts without a done pulse.
    start_op(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_dout", dout, '0);
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_done", 128'(done), 128'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    check("midrst_no_done", 128'(pulses), 128'd0);
    d = {$urandom, $urandom, $urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    run_check("midrst_fresh", d, k, ref_aes(d, k));
    tick();

    for (int n = 0; n < 10; n++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      run_check($sformatf("rand%0d", n), d, k, ref_aes(d, k));
      if ((n % 2) == 1) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
